rx_frame_parser: RTL and testbench
==================================

// Module: rx_frame_parser
// PURPOSE
//  Consumer of the RX byte FIFO filled by the SNI receive stage, on the user side.
//  Pops bytes tagged with an end-of-data (EOD) flag; FCS is already stripped.
//  Splits off the 14-byte Ethernet header (dst MAC, src MAC, EtherType).
//  Streams the payload over valid/ready to the switch core, with runt/giant
//  length checking and a frame-drop path.
// PARAMETERS
//  MIN_LEN  60    minimum legal frame length in bytes (header+payload, FCS excluded)
//  MAX_LEN  1514  maximum legal frame length in bytes (FCS excluded)
// PORTS
//  clk           in   1   user clock
//  arst_n        in   1   async active-low reset; the FIFO shares it
//  fifo_empty    in   1   FIFO empty (first-word-fall-through FIFO)
//  fifo_dout     in   8   FIFO head byte, valid while ~fifo_empty
//  fifo_EOD_out  in   1   head byte is the last byte of its frame
//  fifo_rden     out  1   pop head byte (combinational)
//  hdr_valid     out  1   1-cycle pulse: header fields updated
//  dst_mac       out  48  destination MAC; byte 0 in [47:40]
//  src_mac       out  48  source MAC; byte 6 in [47:40]
//  ethertype     out  16  bytes 12,13; byte 12 in [15:8]
//  out_data      out  8   payload byte (= fifo_dout)
//  out_valid     out  1   payload byte available
//  out_ready     in   1   downstream accepts byte
//  out_sop       out  1   first payload byte
//  out_eop       out  1   last payload byte of frame
//  out_err       out  1   valid with out_eop: frame is runt or giant
//  frame_len     out  11  total byte count of last completed frame
//  frame_done    out  1   1-cycle pulse: frame_len updated
//  runt_pulse    out  1   1-cycle pulse: frame shorter than MIN_LEN
//  giant_pulse   out  1   1-cycle pulse: frame reached MAX_LEN without EOD
// BEHAVIOUR
//  Reset: STATE=S_HDR, byte_cnt=0, all pulses/flags 0, MAC/type/frame_len = 0.
//  Reset mid-frame aborts at once; no eop is emitted; FIFO is cleared by the same reset.
//  byte_cnt (11b) counts pops in the current frame; it is cleared when the EOD byte is popped.
//  FSM (2b state; the undefined encoding goes to S_DROP):
//   S_HDR: fifo_rden = ~fifo_empty; the popped byte shifts into the header register
//     selected by byte_cnt.
//    - Pop with EOD while byte_cnt<=13: runt_pulse=1 and frame_done=1 (frame_len=byte_cnt+1)
//      next cycle. No hdr_valid, no payload. Stay in S_HDR.
//    - Pop of byte 13 without EOD: hdr_valid=1 next cycle. Go to S_PAYLOAD.
//   S_PAYLOAD: out_valid = ~fifo_empty; fifo_rden = out_valid & out_ready.
//    - out_data=fifo_dout and out_eop=fifo_EOD_out (combinational).
//    - out_sop=1 on beats while byte_cnt==14.
//    - The first beat may coincide with the hdr_valid cycle.
//    - A byte is transferred only on valid&ready; data is held stable under backpressure.
//    - EOD pop: frame_done=1 next cycle. out_err=(byte_cnt+1<MIN_LEN) on that beat,
//      plus runt_pulse next cycle if set. Go to S_HDR.
//    - Non-EOD pop with byte_cnt+1==MAX_LEN: force out_eop=1 and out_err=1 on that beat.
//      giant_pulse=1 and frame_done=1 (frame_len=MAX_LEN) next cycle. Go to S_DROP.
//   S_DROP: fifo_rden = ~fifo_empty; out_valid=0; discard bytes until the EOD pop, then S_HDR.
//  Simultaneous MAX_LEN-th byte with EOD: normal end of frame; no giant.
//  Empty FIFO in any state: no pop, state and counters hold.
//  Header fields hold until the next hdr_valid. Pulses never last more than 1 cycle.
// TESTING
//  1 64B frame, dst=01:02:03:04:05:06, type=0800, out_ready=1 -> hdr_valid with those
//    fields; 50 beats with sop on 1st, eop on 50th; out_err=0; frame_len=64.
//  2 Same frame, out_ready toggling 1010.. -> identical 50-byte sequence;
//    fifo_rden never high while out_ready=0.
//  3 10B frame (EOD on 10th byte) -> runt_pulse, frame_len=10, no hdr_valid, no out_valid.
//  4 40B frame -> 26 beats; eop with out_err=1; runt_pulse; frame_len=40.
//  5 1600B frame then 64B frame -> eop+err on payload beat 1500; giant_pulse; 86 bytes
//    dropped; second frame parsed as in test 1.
//  6 arst_n pulsed during payload beat 20, FIFO refilled with a 64B frame -> outputs at
//    reset values; next frame parsed exactly as in test 1.

Source files
------------

// File: rtl/rx_frame_parser_if.sv
// Byte-wide valid/ready payload stream from the RX frame parser to the switch core.
interface rx_frame_parser_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_sop;
  logic       out_eop;
  logic       out_err;

  modport master (output out_data, out_valid, out_sop, out_eop, out_err,
                  input  out_ready);
  modport slave  (input  out_data, out_valid, out_sop, out_eop, out_err,
                  output out_ready);
endinterface

// File: rtl/rx_frame_parser.sv
// Pops EOD-tagged bytes from the RX FIFO, splits off the 14-byte Ethernet header and
// streams the payload downstream with runt/giant length checking and a drop path.
module rx_frame_parser #(
  parameter int MIN_LEN = 60,
  parameter int MAX_LEN = 1514
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic                     fifo_empty,
  input  logic [7:0]               fifo_dout,
  input  logic                     fifo_EOD_out,
  output logic                     fifo_rden,
  output logic                     hdr_valid,
  output logic [47:0]              dst_mac,
  output logic [47:0]              src_mac,
  output logic [15:0]              ethertype,
  output logic [10:0]              frame_len,
  output logic                     frame_done,
  output logic                     runt_pulse,
  output logic                     giant_pulse,
  rx_frame_parser_if.master        out_if
);

  typedef enum logic [1:0] {
    S_HDR     = 2'd0,
    S_PAYLOAD = 2'd1,
    S_DROP    = 2'd2
  } state_t;

  localparam logic [10:0] MinLen = 11'(MIN_LEN);
  localparam logic [10:0] MaxLen = 11'(MAX_LEN);

  state_t        state_q, state_d;
  logic [10:0]   byte_cnt_q, byte_cnt_d;
  logic [10:0]   cnt_inc;
  logic [103:0]  hdr_sh_q;
  logic [47:0]   dst_mac_q, src_mac_q;
  logic [15:0]   ethertype_q;
  logic [10:0]   frame_len_q, frame_len_d;
  logic          hdr_valid_q, hdr_valid_d;
  logic          frame_done_q, frame_done_d;
  logic          runt_q, runt_d;
  logic          giant_q, giant_d;
  logic          pop;
  logic          hdr_load;
  logic          out_valid, out_sop, out_eop, out_err;

  assign cnt_inc = byte_cnt_q + 11'd1;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    frame_len_d  = frame_len_q;
    hdr_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    runt_d       = 1'b0;
    giant_d      = 1'b0;
    hdr_load     = 1'b0;
    pop          = 1'b0;
    out_valid    = 1'b0;
    out_sop      = 1'b0;
    out_eop      = 1'b0;
    out_err      = 1'b0;

    case (state_q)
      S_HDR: begin
        pop = ~fifo_empty;
        if (pop) begin
          if (fifo_EOD_out) begin
            byte_cnt_d   = '0;
            frame_done_d = 1'b1;
            runt_d       = 1'b1;
            frame_len_d  = cnt_inc;
          end else begin
            byte_cnt_d = cnt_inc;
            if (byte_cnt_q == 11'd13) begin
              hdr_load    = 1'b1;
              hdr_valid_d = 1'b1;
              state_d     = S_PAYLOAD;
            end
          end
        end
      end

      S_PAYLOAD: begin
        out_valid = ~fifo_empty;
        pop       = out_valid & out_if.out_ready;
        out_sop   = out_valid & (byte_cnt_q == 11'd14);
        // An EOD on the MAX_LEN-th byte is a normal end of frame, so EOD wins.
        if (out_valid) begin
          if (fifo_EOD_out) begin
            out_eop = 1'b1;
            out_err = (cnt_inc < MinLen);
          end else if (cnt_inc == MaxLen) begin
            out_eop = 1'b1;
            out_err = 1'b1;
          end
        end
        if (pop) begin
          if (fifo_EOD_out) begin
            byte_cnt_d   = '0;
            frame_done_d = 1'b1;
            frame_len_d  = cnt_inc;
            runt_d       = (cnt_inc < MinLen);
            state_d      = S_HDR;
          end else if (cnt_inc == MaxLen) begin
            byte_cnt_d   = cnt_inc;
            frame_done_d = 1'b1;
            giant_d      = 1'b1;
            frame_len_d  = MaxLen;
            state_d      = S_DROP;
          end else begin
            byte_cnt_d = cnt_inc;
          end
        end
      end

      S_DROP: begin
        pop = ~fifo_empty;
        if (pop && fifo_EOD_out) begin
          byte_cnt_d = '0;
          state_d    = S_HDR;
        end
      end

      default: state_d = S_DROP;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= S_HDR;
      byte_cnt_q   <= '0;
      hdr_sh_q     <= '0;
      dst_mac_q    <= '0;
      src_mac_q    <= '0;
      ethertype_q  <= '0;
      frame_len_q  <= '0;
      hdr_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      runt_q       <= 1'b0;
      giant_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register sample pre-edge values.
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      frame_len_q  <= frame_len_d;
      hdr_valid_q  <= hdr_valid_d;
      frame_done_q <= frame_done_d;
      runt_q       <= runt_d;
      giant_q      <= giant_d;
      if (pop && state_q == S_HDR) hdr_sh_q <= {hdr_sh_q[95:0], fifo_dout};
      // Bytes 0..12 sit in the shift register; byte 13 is the head byte right now.
      if (hdr_load) begin
        dst_mac_q   <= hdr_sh_q[103:56];
        src_mac_q   <= hdr_sh_q[55:8];
        ethertype_q <= {hdr_sh_q[7:0], fifo_dout};
      end
    end
  end

  assign fifo_rden        = pop;
  assign hdr_valid        = hdr_valid_q;
  assign dst_mac          = dst_mac_q;
  assign src_mac          = src_mac_q;
  assign ethertype        = ethertype_q;
  assign frame_len        = frame_len_q;
  assign frame_done       = frame_done_q;
  assign runt_pulse       = runt_q;
  assign giant_pulse      = giant_q;
  assign out_if.out_data  = fifo_dout;
  assign out_if.out_valid = out_valid;
  assign out_if.out_sop   = out_sop;
  assign out_if.out_eop   = out_eop;
  assign out_if.out_err   = out_err;

endmodule

// File: tb/tb_rx_frame_parser.sv
// Scoreboard bench for rx_frame_parser: a queue-backed FWFT FIFO model feeds frames,
// expected beats/headers/frame results are queued at push time and popped by a monitor.
module tb_rx_frame_parser;

  localparam int MIN_LEN = 60;
  localparam int MAX_LEN = 1514;
  localparam logic [47:0] EXP_DST  = 48'h010203040506;
  localparam logic [47:0] EXP_SRC  = 48'hA6A7A8A9AAAB;
  localparam logic [15:0] EXP_TYPE = 16'h0800;

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
    logic       err;
  } beat_t;

  typedef struct packed {
    logic [10:0] len;
    logic        runt;
    logic        giant;
  } done_t;

  typedef struct packed {
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] etype;
  } hdr_t;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        fifo_empty;
  logic [7:0]  fifo_dout;
  logic        fifo_EOD_out;
  logic        fifo_rden;
  logic        hdr_valid;
  logic [47:0] dst_mac;
  logic [47:0] src_mac;
  logic [15:0] ethertype;
  logic [10:0] frame_len;
  logic        frame_done;
  logic        runt_pulse;
  logic        giant_pulse;

  rx_frame_parser_if bus ();

  rx_frame_parser #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .fifo_empty   (fifo_empty),
    .fifo_dout    (fifo_dout),
    .fifo_EOD_out (fifo_EOD_out),
    .fifo_rden    (fifo_rden),
    .hdr_valid    (hdr_valid),
    .dst_mac      (dst_mac),
    .src_mac      (src_mac),
    .ethertype    (ethertype),
    .frame_len    (frame_len),
    .frame_done   (frame_done),
    .runt_pulse   (runt_pulse),
    .giant_pulse  (giant_pulse),
    .out_if       (bus)
  );

  always #5 clk = ~clk;

  logic [8:0] fifo_q[$];
  beat_t      exp_beat_q[$];
  done_t      exp_done_q[$];
  hdr_t       exp_hdr_q[$];

  int checks = 0;
  int failures = 0;
  int beats_seen = 0;
  int hdr_seen = 0;
  int runt_seen = 0;
  int giant_seen = 0;

  beat_t mon_beat;
  done_t mon_done;
  hdr_t  mon_hdr;
  logic  pop_now;

  task automatic fifo_refresh();
    if (fifo_q.size() == 0) begin
      fifo_empty   = 1'b1;
      fifo_dout    = 8'h00;
      fifo_EOD_out = 1'b0;
    end else begin
      fifo_empty   = 1'b0;
      fifo_dout    = fifo_q[0][7:0];
      fifo_EOD_out = fifo_q[0][8];
    end
  endtask

  // FIFO model: the pop seen at the edge takes effect just after it.
  always @(posedge clk) begin
    pop_now = fifo_rden & arst_n;
    #1;
    if (pop_now && fifo_q.size() != 0) begin
      void'(fifo_q.pop_front());
      fifo_refresh();
    end
  end

  function automatic logic [7:0] frame_byte(input int i, input logic [7:0] seed);
    if (i < 6)   return 8'(i + 1);
    if (i < 12)  return 8'(8'hA0 + 8'(i));
    if (i == 12) return 8'h08;
    if (i == 13) return 8'h00;
    return 8'(seed + 8'(i * 3));
  endfunction

  // Queue the frame bytes and everything the parser should produce for them.
  task automatic push_frame(input int n, input logic [7:0] seed);
    logic [7:0] b;
    beat_t      eb;
    done_t      ed;
    for (int i = 0; i < n; i++) begin
      b = frame_byte(i, seed);
      fifo_q.push_back({(i == n - 1), b});
      if (n > 14 && i >= 14 && i < MAX_LEN) begin
        eb.data = b;
        eb.sop  = (i == 14);
        if (n <= MAX_LEN) begin
          eb.eop = (i == n - 1);
          eb.err = (i == n - 1) && (n < MIN_LEN);
        end else begin
          eb.eop = (i == MAX_LEN - 1);
          eb.err = (i == MAX_LEN - 1);
        end
        exp_beat_q.push_back(eb);
      end
    end
    if (n > 14) exp_hdr_q.push_back({EXP_DST, EXP_SRC, EXP_TYPE});
    ed.len   = (n > MAX_LEN) ? 11'(MAX_LEN) : 11'(n);
    ed.runt  = (n < MIN_LEN);
    ed.giant = (n > MAX_LEN);
    exp_done_q.push_back(ed);
    fifo_refresh();
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (arst_n) begin
      if (bus.out_valid && bus.out_ready) begin
        beats_seen++;
        checks++;
        if (exp_beat_q.size() == 0) begin
          failures++;
          $display("FAIL beat_unexpected got data=%h sop=%b eop=%b err=%b want no beat",
                   bus.out_data, bus.out_sop, bus.out_eop, bus.out_err);
        end else begin
          mon_beat = exp_beat_q.pop_front();
          if ({bus.out_data, bus.out_sop, bus.out_eop, bus.out_err} !== mon_beat) begin
            failures++;
            $display("FAIL beat got data=%h sop=%b eop=%b err=%b want data=%h sop=%b eop=%b err=%b",
                     bus.out_data, bus.out_sop, bus.out_eop, bus.out_err,
                     mon_beat.data, mon_beat.sop, mon_beat.eop, mon_beat.err);
          end
        end
      end
      if (bus.out_valid && !bus.out_ready) begin
        checks++;
        if (fifo_rden !== 1'b0) begin
          failures++;
          $display("FAIL rden_backpressure got fifo_rden=%b want 0", fifo_rden);
        end
      end
      if (hdr_valid) begin
        hdr_seen++;
        checks++;
        if (exp_hdr_q.size() == 0) begin
          failures++;
          $display("FAIL hdr_unexpected got hdr_valid=1 want 0");
        end else begin
          mon_hdr = exp_hdr_q.pop_front();
          if ({dst_mac, src_mac, ethertype} !== mon_hdr) begin
            failures++;
            $display("FAIL hdr got dst=%h src=%h type=%h want dst=%h src=%h type=%h",
                     dst_mac, src_mac, ethertype, mon_hdr.dst, mon_hdr.src, mon_hdr.etype);
          end
        end
      end
      if (runt_pulse)  runt_seen++;
      if (giant_pulse) giant_seen++;
      if (frame_done) begin
        checks++;
        if (exp_done_q.size() == 0) begin
          failures++;
          $display("FAIL done_unexpected got frame_done=1 len=%0d want none", frame_len);
        end else begin
          mon_done = exp_done_q.pop_front();
          if ({frame_len, runt_pulse, giant_pulse} !== mon_done) begin
            failures++;
            $display("FAIL done got len=%0d runt=%b giant=%b want len=%0d runt=%b giant=%b",
                     frame_len, runt_pulse, giant_pulse, mon_done.len, mon_done.runt, mon_done.giant);
          end
        end
      end else if (runt_pulse || giant_pulse) begin
        checks++;
        failures++;
        $display("FAIL stray_pulse got runt=%b giant=%b without frame_done want 0 0",
                 runt_pulse, giant_pulse);
      end
    end
  end

  // Step cycles until the FIFO and all expectations drain, then a few extra for stray pulses.
  task automatic run_until_idle(input int budget, input bit toggle);
    int n = 0;
    while ((fifo_q.size() != 0 || exp_beat_q.size() != 0 || exp_hdr_q.size() != 0 ||
            exp_done_q.size() != 0) && n < budget) begin
      @(posedge clk);
      #1;
      if (toggle) bus.out_ready = ~bus.out_ready;
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL idle_timeout got fifo=%0d beats=%0d hdr=%0d done=%0d pending want 0",
               fifo_q.size(), exp_beat_q.size(), exp_hdr_q.size(), exp_done_q.size());
    end
    bus.out_ready = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    bus.out_ready = 1'b1;
    fifo_refresh();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({hdr_valid, frame_done, runt_pulse, giant_pulse, bus.out_valid, fifo_rden} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags got hv=%b fd=%b rp=%b gp=%b ov=%b rd=%b want all 0",
               hdr_valid, frame_done, runt_pulse, giant_pulse, bus.out_valid, fifo_rden);
    end
    checks++;
    if ({dst_mac, src_mac, ethertype, frame_len} !== '0) begin
      failures++;
      $display("FAIL reset_fields got dst=%h src=%h type=%h len=%0d want 0",
               dst_mac, src_mac, ethertype, frame_len);
    end
    arst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int b0 = beats_seen;
    push_frame(64, 8'h11);
    run_until_idle(500, 1'b0);
    checks++;
    if (beats_seen - b0 !== 50) begin
      failures++;
      $display("FAIL basic_beats got %0d want 50", beats_seen - b0);
    end
    checks++;
    if ({frame_len, dst_mac, ethertype} !== {11'd64, EXP_DST, EXP_TYPE}) begin
      failures++;
      $display("FAIL basic_fields got len=%0d dst=%h type=%h want len=64 dst=%h type=%h",
               frame_len, dst_mac, ethertype, EXP_DST, EXP_TYPE);
    end
  endtask

  task automatic test_backpressure();
    int b0 = beats_seen;
    push_frame(64, 8'h11);
    run_until_idle(800, 1'b1);
    checks++;
    if (beats_seen - b0 !== 50) begin
      failures++;
      $display("FAIL bp_beats got %0d want 50", beats_seen - b0);
    end
  endtask

  task automatic test_runt_short();
    int b0 = beats_seen;
    int h0 = hdr_seen;
    int r0 = runt_seen;
    push_frame(10, 8'h22);
    run_until_idle(200, 1'b0);
    checks++;
    if ({beats_seen - b0, hdr_seen - h0, runt_seen - r0} !== {32'd0, 32'd0, 32'd1}) begin
      failures++;
      $display("FAIL runt10_counts got beats=%0d hdr=%0d runt=%0d want 0 0 1",
               beats_seen - b0, hdr_seen - h0, runt_seen - r0);
    end
    checks++;
    if (frame_len !== 11'd10) begin
      failures++;
      $display("FAIL runt10_len got %0d want 10", frame_len);
    end
  endtask

  task automatic test_runt_payload();
    int b0 = beats_seen;
    int r0 = runt_seen;
    push_frame(40, 8'h33);
    run_until_idle(300, 1'b0);
    checks++;
    if ({beats_seen - b0, runt_seen - r0, 21'(frame_len)} !== {32'd26, 32'd1, 21'd40}) begin
      failures++;
      $display("FAIL runt40 got beats=%0d runt=%0d len=%0d want 26 1 40",
               beats_seen - b0, runt_seen - r0, frame_len);
    end
  endtask

  task automatic test_min_boundary();
    int r0 = runt_seen;
    push_frame(59, 8'h40);
    push_frame(60, 8'h41);
    run_until_idle(500, 1'b0);
    checks++;
    if ({runt_seen - r0, 21'(frame_len)} !== {32'd1, 21'd60}) begin
      failures++;
      $display("FAIL min_boundary got runt=%0d len=%0d want 1 60", runt_seen - r0, frame_len);
    end
  endtask

  task automatic test_giant();
    int b0 = beats_seen;
    int g0 = giant_seen;
    push_frame(1600, 8'h66);
    push_frame(64, 8'h77);
    run_until_idle(5000, 1'b0);
    checks++;
    if ({beats_seen - b0, giant_seen - g0} !== {32'd1550, 32'd1}) begin
      failures++;
      $display("FAIL giant_counts got beats=%0d giant=%0d want 1550 1",
               beats_seen - b0, giant_seen - g0);
    end
    checks++;
    if ({frame_len, dst_mac} !== {11'd64, EXP_DST}) begin
      failures++;
      $display("FAIL giant_next got len=%0d dst=%h want 64 %h", frame_len, dst_mac, EXP_DST);
    end
  endtask

  task automatic test_max_exact();
    int b0 = beats_seen;
    int g0 = giant_seen;
    push_frame(MAX_LEN, 8'h88);
    run_until_idle(4000, 1'b0);
    checks++;
    if ({beats_seen - b0, giant_seen - g0, 21'(frame_len)} !== {32'd1500, 32'd0, 21'd1514}) begin
      failures++;
      $display("FAIL max_exact got beats=%0d giant=%0d len=%0d want 1500 0 1514",
               beats_seen - b0, giant_seen - g0, frame_len);
    end
  endtask

  task automatic test_reset_mid();
    int b0 = beats_seen;
    int n = 0;
    push_frame(64, 8'h99);
    while (beats_seen < b0 + 19 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (beats_seen < b0 + 19) begin
      failures++;
      $display("FAIL rst_mid_timeout got beats=%0d want 19", beats_seen - b0);
    end
    arst_n = 1'b0;
    fifo_q.delete();
    exp_beat_q.delete();
    exp_hdr_q.delete();
    exp_done_q.delete();
    fifo_refresh();
    #2;
    checks++;
    if ({hdr_valid, frame_done, runt_pulse, giant_pulse, bus.out_valid, fifo_rden} !== 6'b0) begin
      failures++;
      $display("FAIL rst_mid_flags got hv=%b fd=%b rp=%b gp=%b ov=%b rd=%b want all 0",
               hdr_valid, frame_done, runt_pulse, giant_pulse, bus.out_valid, fifo_rden);
    end
    checks++;
    if ({dst_mac, src_mac, ethertype, frame_len} !== '0) begin
      failures++;
      $display("FAIL rst_mid_fields got dst=%h src=%h type=%h len=%0d want 0",
               dst_mac, src_mac, ethertype, frame_len);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    b0 = beats_seen;
    push_frame(64, 8'hAA);
    run_until_idle(500, 1'b0);
    checks++;
    if ({beats_seen - b0, 21'(frame_len)} !== {32'd50, 21'd64} || dst_mac !== EXP_DST) begin
      failures++;
      $display("FAIL rst_mid_next got beats=%0d len=%0d dst=%h want 50 64 %h",
               beats_seen - b0, frame_len, dst_mac, EXP_DST);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_runt_short();
    test_runt_payload();
    test_min_boundary();
    test_giant();
    test_max_exact();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
